// File: rtl/nn_pkg.sv
// Shared types and FP32 helpers for the neuron accumulator.
// fp32_gt is a plain sign-magnitude compare; NaN/Inf get no special treatment.
package nn_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    FIN   = 2'd3
  } nn_acc_state_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;

  // +0 and -0 are equal; otherwise sign decides, then magnitude (reversed when negative).
  function automatic logic fp32_gt(input fp32_t a, input fp32_t b);
    logic both_zero;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (both_zero)        return 1'b0;
    else if (a[31] != b[31]) return !a[31];
    else if (!a[31])      return a[30:0] > b[30:0];
    else                  return a[30:0] < b[30:0];
  endfunction

  function automatic fp32_t fp32_relu(input fp32_t x);
    return x[31] ? FP32_ZERO : x;
  endfunction

endpackage

// File: rtl/nn_neuron_accum_if.sv
// Partition-result input stream and neuron-result output stream.
import nn_pkg::*;

// Both streams: a beat transfers on a rising edge where valid && ready; the
// producer holds valid and payload stable until then, and ready never depends on valid.
interface nn_neuron_accum_if #(parameter int IDX_W = 3);
  logic             in_valid;
  logic             in_ready;
  fp32_t            in_data;
  logic             out_valid;
  logic             out_ready;
  fp32_t            out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_idx, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_idx, out_last);
endinterface

// File: rtl/Float_Add.sv
// Combinational FP32 adder shared with the dot-product datapath.
// Truncating rounding; subnormals flush to zero, exponent overflow saturates to Inf.
module Float_Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic              w_swap;
  logic [31:0]       w_big;
  logic [31:0]       w_sml;
  logic [23:0]       w_m_big;
  logic [23:0]       w_m_sml;
  logic [23:0]       w_m_sh;
  logic [23:0]       w_mant;
  logic [7:0]        w_shamt;
  logic [24:0]       w_sum;
  logic [4:0]        w_lz;
  logic              w_found;
  logic signed [9:0] w_exp;

  always_comb begin
    // Ordering by magnitude keeps the subtraction non-negative.
    w_swap  = (a[30:0] < b[30:0]);
    w_big   = w_swap ? b : a;
    w_sml   = w_swap ? a : b;
    w_m_big = (w_big[30:23] == 8'd0) ? 24'd0 : {1'b1, w_big[22:0]};
    w_m_sml = (w_sml[30:23] == 8'd0) ? 24'd0 : {1'b1, w_sml[22:0]};
    w_shamt = w_big[30:23] - w_sml[30:23];
    w_m_sh  = (w_shamt > 8'd23) ? 24'd0 : (w_m_sml >> w_shamt);
    w_exp   = $signed({2'b00, w_big[30:23]});
    w_lz    = 5'd0;
    w_found = 1'b0;
    w_mant  = 24'd0;
    if (w_big[31] == w_sml[31]) w_sum = {1'b0, w_m_big} + {1'b0, w_m_sh};
    else                        w_sum = {1'b0, w_m_big} - {1'b0, w_m_sh};
    if (w_sum[24]) begin
      w_mant = w_sum[24:1];
      w_exp  = w_exp + 10'sd1;
    end else begin
      for (int i = 23; i >= 0; i--) begin
        if (!w_found && w_sum[i]) begin
          w_lz    = 5'(23 - i);
          w_found = 1'b1;
        end
      end
      w_mant = w_sum[23:0] << w_lz;
      w_exp  = w_exp - $signed({5'd0, w_lz});
    end
    if (w_m_big == 24'd0 || w_sum == 25'd0) y = 32'd0;
    else if (w_exp >= 10'sd255)             y = {w_big[31], 8'hFF, 23'd0};
    else if (w_exp <= 10'sd0)               y = 32'd0;
    else                                    y = {w_big[31], w_exp[7:0], w_mant[22:0]};
  end

endmodule

// File: rtl/nn_argmax_tracker.sv
// Running maximum over emitted neuron values; the first value after clear is always taken,
// later ones only when strictly greater, so ties keep the lower index.
module nn_argmax_tracker
  import nn_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             update,
  input  fp32_t            value,
  input  logic [IDX_W-1:0] idx,
  output fp32_t            best_val,
  output logic [IDX_W-1:0] best_idx
);

  logic r_have;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_have   <= 1'b0;
      best_val <= FP32_ZERO;
      best_idx <= '0;
    end else if (clear) begin
      r_have   <= 1'b0;
      best_val <= FP32_ZERO;
      best_idx <= '0;
    end else if (update) begin
      r_have <= 1'b1;
      if (!r_have || fp32_gt(value, best_val)) begin
        best_val <= value;
        best_idx <= idx;
      end
    end
  end

endmodule

// File: rtl/nn_neuron_accum.sv
// Accumulates NUM_CHUNKS FP32 partial sums per neuron, emits each neuron, tracks argmax.
// Define NN_RELU_EN to apply ReLU to each neuron before emission and argmax.
module nn_neuron_accum
  import nn_pkg::*;
#(
  parameter int NUM_CHUNKS  = 4,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  nn_neuron_accum_if.slave    s,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    argmax_idx,
  output fp32_t               argmax_val,
  output logic                argmax_valid,
  output nn_acc_state_t       dbg_state
);

  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  nn_acc_state_t    r_state;
  nn_acc_state_t    w_next;
  logic [CW-1:0]    r_chunk_cnt;
  logic [IDX_W-1:0] r_neuron_cnt;
  fp32_t            r_acc;
  fp32_t            r_out_data;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;
  logic             r_argmax_valid;
  fp32_t            w_sum;
  fp32_t            w_new;
  fp32_t            w_f;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_done;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_start_fire;
  logic             w_last_chunk;

  Float_Add u_add (.a(r_acc), .b(s.in_data), .y(w_sum));

  // Chunk 0 loads rather than adds, so no accumulator clear cycle is needed.
  assign w_new        = (r_chunk_cnt == '0) ? s.in_data : w_sum;
  assign w_last_chunk = (r_chunk_cnt == CW'(NUM_CHUNKS - 1));
`ifdef NN_RELU_EN
  assign w_f = fp32_relu(w_new);
`else
  assign w_f = w_new;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = ACCUM;
      ACCUM: begin
        w_in_ready = 1'b1;
        if (s.in_valid && w_last_chunk) w_next = EMIT;
      end
      EMIT: begin
        w_out_valid = 1'b1;
        if (s.out_ready) w_next = r_out_last ? FIN : ACCUM;
      end
      FIN: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_in_fire    = s.in_valid && w_in_ready;
  assign w_out_fire   = w_out_valid && s.out_ready;
  assign w_start_fire = (r_state == IDLE) && start;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_chunk_cnt    <= '0;
      r_neuron_cnt   <= '0;
      r_acc          <= FP32_ZERO;
      r_out_data     <= FP32_ZERO;
      r_out_idx      <= '0;
      r_out_last     <= 1'b0;
      r_argmax_valid <= 1'b0;
    end else begin
      if (w_start_fire) begin
        r_chunk_cnt    <= '0;
        r_neuron_cnt   <= '0;
        r_argmax_valid <= 1'b0;
      end
      if (w_in_fire) begin
        r_acc <= w_new;
        if (w_last_chunk) begin
          r_out_data  <= w_f;
          r_out_idx   <= r_neuron_cnt;
          r_out_last  <= (r_neuron_cnt == IDX_W'(NUM_NEURONS - 1));
          r_chunk_cnt <= '0;
        end else begin
          r_chunk_cnt <= r_chunk_cnt + 1'b1;
        end
      end
      if (w_out_fire && !r_out_last) r_neuron_cnt <= r_neuron_cnt + 1'b1;
      if (w_done) r_argmax_valid <= 1'b1;
    end
  end

  nn_argmax_tracker #(.IDX_W(IDX_W)) u_argmax (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (w_start_fire),
    .update   (w_out_fire),
    .value    (r_out_data),
    .idx      (r_out_idx),
    .best_val (argmax_val),
    .best_idx (argmax_idx)
  );

  assign s.in_ready   = w_in_ready;
  assign s.out_valid  = w_out_valid;
  assign s.out_data   = r_out_data;
  assign s.out_idx    = r_out_idx;
  assign s.out_last   = r_out_last;
  assign busy         = (r_state != IDLE);
  assign done         = w_done;
  assign argmax_valid = r_argmax_valid;
  assign dbg_state    = r_state;

endmodule

// File: doc/nn_neuron_accum.md
Name: nn_neuron_accum

Overview:
- Downstream consumer of the 16-input partition dot-product datapath.
- Accumulates NUM_CHUNKS partial sums (FP32) into one neuron value, with optional ReLU.
- Emits each neuron on a valid/ready stream and tracks the running argmax over NUM_NEURONS neurons, so the final layer yields the predicted intent class.
- Upstream contract: the bias is carried only in chunk 0; the feeder drives bias = 0 for all later chunks.

Parameters:
- NUM_CHUNKS, 4, partition results per neuron (layer fan-in / 16); must be >= 1.
- NUM_NEURONS, 8, neurons per layer pass; must be >= 1.
- IDX_W, $clog2(NUM_NEURONS) (min 1), width of neuron/class indices.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer pass; honoured only in IDLE.
- in_valid  in  1  partition result valid.
- in_ready  out  1  accumulator accepts a partition result.
- in_data  in  32  FP32 partition output.
- out_valid  out  1  neuron result valid.
- out_ready  in  1  downstream accepts the neuron result.
- out_data  out  32  FP32 neuron value (post-ReLU if enabled).
- out_idx  out  IDX_W  index of the neuron on out_data.
- out_last  out  1  high with the final neuron of the pass.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on pass completion.
- argmax_idx  out  IDX_W  index of the maximum neuron; valid while argmax_valid.
- argmax_val  out  32  FP32 maximum value.
- argmax_valid  out  1  set at done; cleared by the next accepted start or by Reset.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs, the accumulator and all counters go to 0.
  - Any partial pass is discarded.
- States: IDLE, ACCUM, EMIT, FIN.
- IDLE:
  - in_ready = 0.
  - start = 1 moves to ACCUM, clears chunk_cnt, neuron_cnt and argmax_valid.
- ACCUM:
  - in_ready = 1; one chunk is accepted per cycle on in_valid && in_ready.
  - chunk_cnt == 0: acc <= in_data.
  - otherwise: acc <= acc + in_data, using the existing combinational Float_Add.
  - On the handshake with chunk_cnt == NUM_CHUNKS-1:
    - out_data <= f(acc + in_data), where f is the ReLU or identity.
    - out_idx <= neuron_cnt.
    - out_last <= (neuron_cnt == NUM_NEURONS-1).
    - chunk_cnt <= 0; go to EMIT.
  - NUM_CHUNKS == 1: the accepted value passes straight through f.
- EMIT:
  - out_valid = 1 and in_ready = 0.
  - out_data, out_idx and out_last are held stable until out_ready.
  - On out_valid && out_ready:
    - Argmax update: take the value if neuron_cnt == 0 or fgt(out_data, argmax_val). Ties keep the lower index.
    - If out_last, go to FIN; otherwise neuron_cnt++ and go to ACCUM.
- FIN:
  - done = 1 for one cycle, argmax_valid <= 1, go to IDLE.
- Latency and throughput:
  - out_valid rises on the cycle after the last-chunk handshake.
  - Peak rate is one neuron per NUM_CHUNKS+1 cycles.
- start outside IDLE is ignored and has no effect.
- fgt(a,b), sign-magnitude compare:
  - +0 and -0 compare equal.
  - Opposite signs: the positive value is greater, unless both are zero.
  - Both positive: compare a[30:0] > b[30:0].
  - Both negative: compare a[30:0] < b[30:0].
  - NaN/Inf inputs use the same bit rule; no special handling.
- Counters never wrap: chunk_cnt and neuron_cnt are bounded by the state transitions.

Optional Feature:
- Macro: NN_RELU_EN.
- Defined: f(x) = 0x00000000 when x[31] = 1 (including -0); otherwise x. Argmax operates on post-ReLU values.
- Undefined: f(x) = x; raw FP32 sums are emitted and compared.

Decomposition:
- Package nn_pkg holds:
  - typedef fp32_t (logic [31:0]);
  - state enum nn_acc_state_t;
  - constant FP32_ZERO;
  - function fp32_gt (fgt above);
  - function fp32_relu.
- One sub-module: nn_argmax_tracker, with inputs Clk, Reset, clear, update, value, idx and outputs best_val, best_idx.
- The accumulator reuses Float_Add; no new adder.

Test Plan:
- Accumulation: NUM_CHUNKS=4, neuron 0 fed chunks 0x3F800000 x4 (1.0 each) -> out_data = 0x40800000 (4.0), out_idx = 0, out_valid on the cycle after the 4th handshake.
- ReLU: chunks sum to -3.0.
  - With NN_RELU_EN: out_data = 0x00000000.
  - Without: out_data = 0xC0400000.
- Backpressure: hold out_ready = 0 for 5 cycles in EMIT -> out_data and out_idx stable, in_ready = 0, no chunks consumed; release -> next neuron begins.
- Argmax with tie: NUM_NEURONS=4, values 0.5 (0x3F000000), 2.0 (0x40000000), 2.0, -1.0 (0xBF800000) -> argmax_idx = 1, argmax_val = 0x40000000, done pulses one cycle after the out_last handshake.
- Reset mid-pass: assert Reset after 2 chunks of neuron 0 -> all outputs 0 and busy = 0; new start with chunks 0.5 x4 -> out_data = 0x40000000.
- Start while busy: pulse start during ACCUM and EMIT -> no counter reset; pass completes with correct out_idx sequence 0..NUM_NEURONS-1.
